// File: rtl/instruction_fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Purpose  : Bundles the fetch unit's memory read port, the decode-side
//            valid/ready delivery channel and the execute-side control inputs.
// Ports    : AddressBus/InstructionReg  - instruction memory read port
//            instr_out/instr_pc/instr_valid/instr_ready - delivery to decode
//            redirect_valid/redirect_target/halt_request/halted - execute ctrl
// Modports : master - the fetch unit; slave - memory/decode/execute side
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AddressBus;
  logic [DATA_WIDTH-1:0] InstructionReg;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  halt_request;
  logic                  halted;

  modport master (
    output AddressBus,
    input  InstructionReg,
    output instr_out,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_target,
    input  halt_request,
    output halted
  );

  modport slave (
    input  AddressBus,
    output InstructionReg,
    input  instr_out,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect_valid,
    output redirect_target,
    output halt_request,
    input  halted
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Initiator of the instruction memory read port. Owns the fetch
//            address, keeps at most one read in flight, buffers returned words
//            with their address in a small FIFO and delivers {instr, pc} to
//            decode over valid/ready. Honors redirects and halt requests.
// Ports    : clock    - system clock, all state on posedge
//            reset_n  - asynchronous active-low reset
//            bus      - instruction_fetch_unit_if.master (memory port,
//                       decode channel, redirect/halt control, halted status)
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  wire logic                  clock,
  input  wire logic                  reset_n,
  instruction_fetch_unit_if.master   bus
);

  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_RUN    = 2'd1;
  localparam logic [1:0] c_FLUSH  = 2'd2;
  localparam logic [1:0] c_HALTED = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic                  w_run_en;
  logic                  w_halted;

  // r_addr is the address currently on the bus; the memory samples it at the
  // next posedge, so "issuing" commits that value as the in-flight read.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;

  logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_redirect;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [c_CNT_W-1:0]    w_occupancy;
  logic                  w_issue;

  // Redirects are ignored during the single start-up cycle.
  assign w_redirect  = bus.redirect_valid && (r_state != c_IDLE);
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && bus.instr_ready;
  // A redirect kills the word returning this cycle.
  assign w_push      = r_inflight && !w_redirect;
  // Entries still owed space after this cycle: survivors plus the word being
  // captured now. Issuing only below depth means a full FIFO is never written.
  assign w_occupancy = r_count - c_CNT_W'(w_pop) + c_CNT_W'(r_inflight);
  assign w_issue     = w_run_en && !w_redirect && (w_occupancy < c_DEPTH);

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ----------------------------------------------------------- FSM next state
  always_comb begin
    w_state_next = r_state;
    if (r_state == c_IDLE) begin
      w_state_next = c_RUN;
    end else if (w_redirect) begin
      w_state_next = bus.halt_request ? c_HALTED : c_FLUSH;
    end else begin
      case (r_state)
        c_RUN:    if (bus.halt_request) w_state_next = c_HALTED;
        c_FLUSH:  w_state_next = bus.halt_request ? c_HALTED : c_RUN;
        c_HALTED: if (!bus.halt_request) w_state_next = c_RUN;
        default:  w_state_next = c_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- FSM outputs
  always_comb begin
    w_run_en = (r_state == c_RUN);
    w_halted = (r_state == c_HALTED) && !r_inflight;
  end

  // ------------------------------------------------------ fetch address path
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_redirect) begin
        r_addr <= bus.redirect_target;
      end else if (w_issue) begin
        r_inflight_pc <= r_addr;
        r_addr        <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // -------------------------------------------------------- fetch FIFO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= bus.InstructionReg;
        r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        r_wr_ptr               <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  assign bus.AddressBus  = r_addr;
  assign bus.instr_out   = r_fifo_instr[r_rd_ptr];
  assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];
  assign bus.instr_valid = w_valid;
  assign bus.halted      = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Self-checking bench for instruction_fetch_unit. Two instances
//            (RESET_PC 0 and FFFFFFFE) share clock, reset and control inputs;
//            each has its own memory model. A flow model tracks the next pc
//            decode must receive; every transfer is compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam int          c_AW    = 32;
  localparam int          c_DW    = 32;
  localparam int          c_DEPTH = 2;
  localparam logic [31:0] c_RPC1  = 32'hFFFF_FFFE;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        tb_ready = 1'b0;
  logic        tb_redir = 1'b0;
  logic        tb_halt  = 1'b0;
  logic [31:0] tb_target = '0;

  int          n_total = 0;
  int          n_bad   = 0;
  int          deliv0  = 0;
  logic [31:0] exp0;
  logic [31:0] exp1;

  instruction_fetch_unit_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus0 ();
  instruction_fetch_unit_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus1 ();

  assign bus0.instr_ready     = tb_ready;
  assign bus0.redirect_valid  = tb_redir;
  assign bus0.redirect_target = tb_target;
  assign bus0.halt_request    = tb_halt;
  assign bus1.instr_ready     = tb_ready;
  assign bus1.redirect_valid  = tb_redir;
  assign bus1.redirect_target = tb_target;
  assign bus1.halt_request    = tb_halt;

  instruction_fetch_unit #(
    .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .RESET_PC(32'h0), .FIFO_DEPTH(c_DEPTH)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0)
  );

  instruction_fetch_unit #(
    .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .RESET_PC(c_RPC1), .FIFO_DEPTH(c_DEPTH)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // Synchronous memory: address sampled at posedge, data valid next cycle.
  always @(posedge clock) begin
    bus0.InstructionReg <= mem_word(bus0.AddressBus);
    bus1.InstructionReg <= mem_word(bus1.AddressBus);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: apply inputs for the coming posedge, score any
  // transfer that posedge will perform, then advance to the next negedge.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] tgt,
                       input logic hr);
    tb_ready  = rdy;
    tb_redir  = rv;
    tb_target = tgt;
    tb_halt   = hr;
    #1;
    if (bus0.instr_valid && rdy) begin
      chk("pc0", bus0.instr_pc, exp0);
      chk("out0", bus0.instr_out, mem_word(exp0));
      exp0++;
      deliv0++;
    end
    if (bus1.instr_valid && rdy) begin
      chk("pc1", bus1.instr_pc, exp1);
      chk("out1", bus1.instr_out, mem_word(exp1));
      exp1++;
    end
    if (rv) begin
      exp0 = tgt;
      exp1 = tgt;
    end
    @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          d;
    logic [31:0] a1;
    logic        halt_lvl;

    // ---------------------------------------------------------------- reset
    repeat (3) @(negedge clock);
    chk("rst_valid0", 32'(bus0.instr_valid), 32'd0);
    chk("rst_addr0", bus0.AddressBus, 32'd0);
    chk("rst_out0", bus0.instr_out, 32'd0);
    chk("rst_pc0", bus0.instr_pc, 32'd0);
    chk("rst_halted0", 32'(bus0.halted), 32'd0);
    chk("rst_addr1", bus1.AddressBus, c_RPC1);
    chk("rst_valid1", 32'(bus1.instr_valid), 32'd0);
    exp0 = 32'd0;
    exp1 = c_RPC1;
    reset_n = 1'b1;

    // ------------------------------- start-up and streaming (incl. wrap)
    // e = posedges since release: e1 is the idle cycle, e2 issues RESET_PC,
    // e3 captures it, then one word per cycle.
    for (int e = 0; e < 10; e++) begin
      a1 = c_RPC1 + ((e == 0) ? 32'd0 : 32'(e - 1));
      chk("t1_addr0", bus0.AddressBus, (e == 0) ? 32'd0 : 32'(e - 1));
      chk("t1_addr1", bus1.AddressBus, a1);
      chk("t1_valid0", 32'(bus0.instr_valid), 32'(e >= 3));
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
    end

    // ------------------------------------------------- back-pressure stall
    for (int s = 0; s < 5; s++) begin
      chk("t2_valid", 32'(bus0.instr_valid), 32'd1);
      chk("t2_pc_stable", bus0.instr_pc, exp0);
      chk("t2_out_stable", bus0.instr_out, mem_word(exp0));
      chk("t2_addr_frozen", bus0.AddressBus, exp0 + 32'(c_DEPTH));
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
    end
    chk("t2_addr_full", bus0.AddressBus, exp0 + 32'(c_DEPTH));
    for (int s = 0; s < 6; s++) begin
      chk("t2_resume_valid", 32'(bus0.instr_valid), 32'd1);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
    end

    // --------------------------------------- redirect with a full FIFO
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    d = deliv0;
    repeat (8) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    chk("t3_live", 32'(deliv0 > d), 32'd1);

    // ------------------------------------------------------------- halt
    repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t4_halted", 32'(bus0.halted), 32'd1);
    for (int s = 0; s < 6; s++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      chk("t4_halted_hold", 32'(bus0.halted), 32'd1);
    end
    chk("t4_drained", 32'(bus0.instr_valid), 32'd0);
    chk("t4_addr0", bus0.AddressBus, exp0);
    chk("t4_addr1", bus1.AddressBus, exp1);
    d = deliv0;
    repeat (8) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    chk("t4_resume_live", 32'(deliv0 > d), 32'd1);

    // --------------------------------------- redirect while halted
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h100, 1'b1);
    chk("t4r_addr", bus0.AddressBus, 32'h100);
    chk("t4r_valid", 32'(bus0.instr_valid), 32'd0);
    chk("t4r_halted", 32'(bus0.halted), 32'd1);
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t4r_addr_hold", bus0.AddressBus, 32'h100);
    d = deliv0;
    repeat (8) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    chk("t4r_live", 32'(deliv0 > d), 32'd1);

    // ------------------------------------------------- randomized traffic
    halt_lvl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) halt_lvl = ~halt_lvl;
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
            $urandom, halt_lvl);
    end
    d = deliv0;
    repeat (10) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    chk("rnd_live", 32'(deliv0 > d), 32'd1);

    // ----------------------------------------- asynchronous reset mid-stream
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t6_pre_valid", 32'(bus0.instr_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid0", 32'(bus0.instr_valid), 32'd0);
    chk("t6_addr0", bus0.AddressBus, 32'd0);
    chk("t6_pc0", bus0.instr_pc, 32'd0);
    chk("t6_addr1", bus1.AddressBus, c_RPC1);
    chk("t6_valid1", 32'(bus1.instr_valid), 32'd0);
    repeat (2) @(negedge clock);
    exp0 = 32'd0;
    exp1 = c_RPC1;
    reset_n = 1'b1;
    d = deliv0;
    repeat (8) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    chk("t6_restart_live", 32'(deliv0 > d), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
